// File: rtl/ppu_ctrl.sv
// Load sequencer for the pattern processing unit: shadows the PPU parameter
// bytes, reloads them at a frame boundary, then forwards PPU pixel bytes.
module ppu_ctrl #(
  parameter int unsigned NBYTES = 10,
  parameter int unsigned TMO    = 255
) (
  input  logic       clk_pix,
  input  logic       rst_pix,
  input  logic       cfg_we,
  input  logic [3:0] cfg_addr,
  input  logic [7:0] cfg_wdata,
  input  logic [2:0] cfg_mode,
  input  logic       cfg_go,
  input  logic       frame_start,
  output logic       ppu_sync,
  output logic [2:0] ppu_mode,
  output logic [7:0] ppu_data_i,
  output logic       ppu_stb_i,
  input  logic       ppu_ack_i,
  input  logic [7:0] ppu_data_o,
  input  logic       ppu_stb_o,
  output logic       ppu_ack_o,
  output logic [7:0] pix_data,
  output logic       busy,
  output logic       loaded,
  output logic       err
);

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 4;
  localparam int unsigned MW = 3;
  localparam int unsigned TW = $clog2(TMO + 1);
  localparam logic [AW:0]   NB_EXT   = (AW + 1)'(NBYTES);
  localparam logic [AW-1:0] LAST_IDX = AW'(NBYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_SEND,
    S_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   shadow_q [NBYTES];
  logic [DW-1:0]   shadow_d [NBYTES];
  logic [DW-1:0]   sbuf_q   [NBYTES];
  logic [DW-1:0]   sbuf_d   [NBYTES];
  logic            pending_q, pending_d;
  logic [MW-1:0]   pend_mode_q, pend_mode_d;
  logic [MW-1:0]   mode_q, mode_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            err_q, err_d;
  logic [DW-1:0]   pix_q, pix_d;
  logic            start_c;

  // State and datapath registers
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      state_q     <= S_IDLE;
      for (int unsigned i = 0; i < NBYTES; i++) begin
        shadow_q[i] <= '0;
        sbuf_q[i]   <= '0;
      end
      pending_q   <= 1'b0;
      pend_mode_q <= '0;
      mode_q      <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      err_q       <= 1'b0;
      pix_q       <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      sbuf_q      <= sbuf_d;
      pending_q   <= pending_d;
      pend_mode_q <= pend_mode_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      err_q       <= err_d;
      pix_q       <= pix_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    sbuf_d      = sbuf_q;
    pending_d   = pending_q;
    pend_mode_d = pend_mode_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    err_d       = err_q;
    pix_d       = pix_q;
    start_c     = 1'b0;

    if (cfg_we && ({1'b0, cfg_addr} < NB_EXT)) begin
      shadow_d[cfg_addr] = cfg_wdata;
    end

    if (cfg_go) begin
      err_d       = 1'b0;
      pend_mode_d = cfg_mode;
    end

    case (state_q)
      S_IDLE, S_RUN: begin
        if (frame_start && pending_q) begin
          start_c = 1'b1;
          state_d = S_SYNC;
          sbuf_d  = shadow_q;
          mode_d  = pend_mode_q;
          cnt_d   = '0;
          tmo_d   = '0;
        end
      end
      S_SYNC: begin
        state_d = S_SEND;
      end
      S_SEND: begin
        if (ppu_ack_i) begin
          tmo_d = '0;
          if (cnt_q == LAST_IDX) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_q == TMO_LAST) begin
          // Timeout wins over a same-cycle cfg_go clear
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cfg_go) begin
      pending_d = 1'b1;
    end else if (start_c) begin
      pending_d = 1'b0;
    end

    // Pixel register only carries data while running
    if (state_d != S_RUN) begin
      pix_d = '0;
    end else if ((state_q == S_RUN) && ppu_stb_o) begin
      pix_d = ppu_data_o;
    end
  end

  assign ppu_sync   = (state_q == S_SYNC) || (state_q == S_SEND);
  assign ppu_stb_i  = (state_q == S_SEND);
  assign ppu_data_i = (state_q == S_SEND) ? sbuf_q[cnt_q] : '0;
  assign ppu_mode   = mode_q;
  assign ppu_ack_o  = (state_q == S_RUN);
  assign loaded     = (state_q == S_RUN);
  assign busy       = ppu_sync;
  assign err        = err_q;
  assign pix_data   = pix_q;

endmodule
